// File: rtl/greedysnake_video_pkg.sv
// Shared 640x480 video timing defaults, map geometry and pixel colours for the snake map renderer.
// Constants only: no logic, no latency.
package greedysnake_video_pkg;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int CELL_SHIFT_DEF = 4;
    localparam int MAP_X0_DEF     = 192;
    localparam int MAP_Y0_DEF     = 112;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic [23:0] COL_SNAKE      = 24'hFF_FF_FF;
    localparam logic [23:0] COL_SNAKE_DEAD = 24'hFF_00_00;
    localparam logic [23:0] COL_EMPTY      = 24'h00_00_00;
    localparam logic [23:0] COL_BORDER     = 24'h00_00_40;
    localparam logic [23:0] COL_GRID       = 24'h40_40_40;

    // One counter width wide enough for whichever of the two totals is larger.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b);
    endfunction

endpackage

// File: rtl/greedysnake_vtiming.sv
// Free-running h/v raster counters with raw active/sync flags and a frame-wrap strobe.
// Counters are registered; the flags are combinational decodes of the current count.
module greedysnake_vtiming import greedysnake_video_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_wrap_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LST_C = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;

    always_comb begin
        h_last  = (h_cnt_q == H_LST_C);
        v_last  = (v_cnt_q == V_LST_C);
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign active_o     = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hsync_o      = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
    assign vsync_o      = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
    assign frame_wrap_o = h_last && v_last;

endmodule

// File: rtl/greedysnake_map_render.sv
// Snapshots the 16x16 snake map, swaps it in at frame wrap and renders it on 640x480 RGB; 1 clk output latency.
// Optional GREEDYSNAKE_GRID_LINES_EN draws grid lines over empty cells.
module greedysnake_map_render import greedysnake_video_pkg::*; #(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CELL_SHIFT = CELL_SHIFT_DEF,
    parameter int MAP_X0     = MAP_X0_DEF,
    parameter int MAP_Y0     = MAP_Y0_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] snake_map_arr_0,
    input  logic [15:0] snake_map_arr_1,
    input  logic [15:0] snake_map_arr_2,
    input  logic [15:0] snake_map_arr_3,
    input  logic [15:0] snake_map_arr_4,
    input  logic [15:0] snake_map_arr_5,
    input  logic [15:0] snake_map_arr_6,
    input  logic [15:0] snake_map_arr_7,
    input  logic [15:0] snake_map_arr_8,
    input  logic [15:0] snake_map_arr_9,
    input  logic [15:0] snake_map_arr_10,
    input  logic [15:0] snake_map_arr_11,
    input  logic [15:0] snake_map_arr_12,
    input  logic [15:0] snake_map_arr_13,
    input  logic [15:0] snake_map_arr_14,
    input  logic [15:0] snake_map_arr_15,
    input  logic        hdmi_tx_en,
    input  logic        game_over_flag,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        map_pending
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W    = cnt_width(H_TOTAL, V_TOTAL);
    localparam int MAP_SPAN = 16 << CELL_SHIFT;

    localparam logic [CNT_W-1:0] MX0_C = CNT_W'(MAP_X0);
    localparam logic [CNT_W-1:0] MX1_C = CNT_W'(MAP_X0 + MAP_SPAN);
    localparam logic [CNT_W-1:0] MY0_C = CNT_W'(MAP_Y0);
    localparam logic [CNT_W-1:0] MY1_C = CNT_W'(MAP_Y0 + MAP_SPAN);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, hsync_on, vsync_on, frame_wrap;

    greedysnake_vtiming #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_vtiming (
        .clk          (clk),
        .rst          (rst),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .active_o     (active),
        .hsync_o      (hsync_on),
        .vsync_o      (vsync_on),
        .frame_wrap_o (frame_wrap)
    );

    logic [15:0][15:0] map_in;

    assign map_in[0]  = snake_map_arr_0;
    assign map_in[1]  = snake_map_arr_1;
    assign map_in[2]  = snake_map_arr_2;
    assign map_in[3]  = snake_map_arr_3;
    assign map_in[4]  = snake_map_arr_4;
    assign map_in[5]  = snake_map_arr_5;
    assign map_in[6]  = snake_map_arr_6;
    assign map_in[7]  = snake_map_arr_7;
    assign map_in[8]  = snake_map_arr_8;
    assign map_in[9]  = snake_map_arr_9;
    assign map_in[10] = snake_map_arr_10;
    assign map_in[11] = snake_map_arr_11;
    assign map_in[12] = snake_map_arr_12;
    assign map_in[13] = snake_map_arr_13;
    assign map_in[14] = snake_map_arr_14;
    assign map_in[15] = snake_map_arr_15;

    logic [15:0][15:0] shadow_q, shadow_d;
    logic [15:0][15:0] disp_q, disp_d;
    logic              shadow_go_q, shadow_go_d;
    logic              disp_go_q, disp_go_d;
    logic              pend_q, pend_d;

    // Swap reads the old shadow; a coincident capture then refills it and keeps pending set.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_go_d = shadow_go_q;
        disp_d      = disp_q;
        disp_go_d   = disp_go_q;
        pend_d      = pend_q;
        if (frame_wrap && pend_q) begin
            disp_d    = shadow_q;
            disp_go_d = shadow_go_q;
            pend_d    = 1'b0;
        end
        if (hdmi_tx_en) begin
            shadow_d    = map_in;
            shadow_go_d = game_over_flag;
            pend_d      = 1'b1;
        end
    end

    logic        in_win;
    logic [3:0]  col, row;
    logic        cell_on;
    logic        grid_on;
    logic [23:0] rgb_d;
    logic        hs_d, vs_d, de_d, fs_d;

    always_comb begin
        in_win  = (h_cnt >= MX0_C) && (h_cnt < MX1_C) && (v_cnt >= MY0_C) && (v_cnt < MY1_C);
        col     = 4'((h_cnt - MX0_C) >> CELL_SHIFT);
        row     = 4'((v_cnt - MY0_C) >> CELL_SHIFT);
        cell_on = disp_q[row][col];
`ifdef GREEDYSNAKE_GRID_LINES_EN
        grid_on = (CELL_SHIFT'(h_cnt - MX0_C) == '0) || (CELL_SHIFT'(v_cnt - MY0_C) == '0);
`else
        grid_on = 1'b0;
`endif
        rgb_d = 24'h0;
        if (active) begin
            if (in_win) begin
                if (cell_on) begin
                    rgb_d = disp_go_q ? COL_SNAKE_DEAD : COL_SNAKE;
                end else begin
                    rgb_d = grid_on ? COL_GRID : COL_EMPTY;
                end
            end else begin
                rgb_d = COL_BORDER;
            end
        end
        hs_d = hsync_on ? SYNC_POL : ~SYNC_POL;
        vs_d = vsync_on ? SYNC_POL : ~SYNC_POL;
        de_d = active;
        fs_d = (h_cnt == '0) && (v_cnt == '0);
    end

    logic        hs_q, vs_q, de_q, fs_q;
    logic [23:0] rgb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q    <= '0;
            shadow_go_q <= 1'b0;
            disp_q      <= '0;
            disp_go_q   <= 1'b0;
            pend_q      <= 1'b0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            rgb_q       <= 24'h0;
        end else begin
            shadow_q    <= shadow_d;
            shadow_go_q <= shadow_go_d;
            disp_q      <= disp_d;
            disp_go_q   <= disp_go_d;
            pend_q      <= pend_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            rgb_q       <= rgb_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;
    assign map_pending = pend_q;

endmodule

// File: tb/tb_greedysnake_map_render.sv
// Directed bench for greedysnake_map_render on a shrunk raster (48x41 total, 2 px cells, map at 4,2).
module tb_greedysnake_map_render;

    localparam int HT    = 48;
    localparam int VT    = 41;
    localparam int FRAME = HT * VT;

    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] C_RED    = 24'hFF0000;
    localparam logic [23:0] C_BLACK  = 24'h000000;
    localparam logic [23:0] C_BORDER = 24'h000040;
`ifdef GREEDYSNAKE_GRID_LINES_EN
    localparam logic [23:0] C_EMPTY_ON_GRID = 24'h404040;
`else
    localparam logic [23:0] C_EMPTY_ON_GRID = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] map_r [16];
    logic        en = 1'b0;
    logic        go = 1'b0;
    logic        hs, vs, de, frame_start, map_pending;
    logic [23:0] rgb;

    int n_cmp = 0;
    int n_bad = 0;
    int pcount;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) pcount <= 0;
        else      pcount <= pcount + 1;
    end

    greedysnake_map_render #(
        .H_ACTIVE (40), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (36), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0), .CELL_SHIFT (1), .MAP_X0 (4), .MAP_Y0 (2)
    ) dut (
        .clk (clk), .rst (rst),
        .snake_map_arr_0 (map_r[0]),   .snake_map_arr_1 (map_r[1]),
        .snake_map_arr_2 (map_r[2]),   .snake_map_arr_3 (map_r[3]),
        .snake_map_arr_4 (map_r[4]),   .snake_map_arr_5 (map_r[5]),
        .snake_map_arr_6 (map_r[6]),   .snake_map_arr_7 (map_r[7]),
        .snake_map_arr_8 (map_r[8]),   .snake_map_arr_9 (map_r[9]),
        .snake_map_arr_10 (map_r[10]), .snake_map_arr_11 (map_r[11]),
        .snake_map_arr_12 (map_r[12]), .snake_map_arr_13 (map_r[13]),
        .snake_map_arr_14 (map_r[14]), .snake_map_arr_15 (map_r[15]),
        .hdmi_tx_en (en), .game_over_flag (go),
        .hs (hs), .vs (vs), .de (de), .rgb (rgb),
        .frame_start (frame_start), .map_pending (map_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the negedge where the outputs show raster position (x,y).
    task automatic wait_out(input int x, input int y);
        bit hit = 1'b0;
        int n;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            @(negedge clk);
            n = pcount;
            if (n > 0 && ((n - 1) % HT) == x && (((n - 1) / HT) % VT) == y) hit = 1'b1;
        end
        if (!hit) check("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        int de_cnt, hs_low, vs_low, fs_cnt;
        for (int i = 0; i < 16; i++) map_r[i] = 16'h0;

        repeat (3) @(negedge clk);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_de", de, 0);
        check("rst_rgb", rgb, 0);
        check("rst_fs", frame_start, 0);
        check("rst_pend", map_pending, 0);

        rst = 1'b1;
        de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("first_fs", frame_start, 1);
                check("first_de", de, 1);
                check("first_rgb_border", rgb, C_BORDER);
            end
            de_cnt += int'(de);
            hs_low += int'(!hs);
            vs_low += int'(!vs);
            fs_cnt += int'(frame_start);
        end
        check("de_count", de_cnt, 40 * 36);
        check("hs_low_count", hs_low, 4 * VT);
        check("vs_low_count", vs_low, 2 * HT);
        check("fs_count", fs_cnt, 1);
        @(negedge clk);
        check("fs_frame2", frame_start, 1);
        wait_out(41, 0);
        check("hs_before_sync", hs, 1);
        wait_out(42, 0);
        check("hs_sync_start", hs, 0);

        // Mid-frame capture stays hidden until the next frame.
        wait_out(0, 1);
        map_r[0] = 16'h0001;
        pulse_en();
        check("pend_after_cap", map_pending, 1);
        wait_out(4, 2);
        check("cell00_old", rgb, C_EMPTY_ON_GRID);
        wait_out(46, 40);
        check("pend_before_wrap", map_pending, 1);
        wait_out(47, 40);
        check("pend_after_wrap", map_pending, 0);
        wait_out(4, 2);
        check("cell00_new", rgb, C_WHITE);
        wait_out(5, 3);
        check("cell00_inner", rgb, C_WHITE);
        wait_out(7, 3);
        check("cell01_empty", rgb, C_BLACK);

        // Far corner cell and window edges.
        wait_out(0, 4);
        map_r[0]  = 16'h0;
        map_r[15] = 16'h8000;
        pulse_en();
        wait_out(35, 33);
        check("corner_old", rgb, C_BLACK);
        wait_out(3, 2);
        check("left_of_win", rgb, C_BORDER);
        wait_out(35, 33);
        check("corner_new", rgb, C_WHITE);
        wait_out(36, 33);
        check("right_of_win", rgb, C_BORDER);

        // Game-over colour.
        wait_out(0, 35);
        map_r[15] = 16'h0;
        map_r[3]  = 16'h0010;
        go = 1'b1;
        pulse_en();
        go = 1'b0;
        wait_out(12, 8);
        check("dead_cell", rgb, C_RED);
        wait_out(35, 33);
        check("corner_cleared", rgb, C_BLACK);

        // Shadow holds A; B captured on the wrap cycle itself.
        wait_out(0, 34);
        map_r[3] = 16'h0;
        map_r[5] = 16'h0002;
        pulse_en();
        wait_out(46, 40);
        map_r[5] = 16'h0004;
        pulse_en();
        check("pend_wrap_cap", map_pending, 1);
        wait_out(7, 13);
        check("A_shown", rgb, C_WHITE);
        wait_out(9, 13);
        check("B_not_yet", rgb, C_BLACK);
        wait_out(47, 40);
        check("pend_B_swapped", map_pending, 0);
        wait_out(7, 13);
        check("A_gone", rgb, C_BLACK);
        wait_out(9, 13);
        check("B_shown", rgb, C_WHITE);

        // Reset mid-frame.
        wait_out(0, 19);
        pulse_en();
        check("pend_pre_rst", map_pending, 1);
        wait_out(0, 20);
        rst = 1'b0;
        #1;
        check("mrst_hs", hs, 1);
        check("mrst_vs", vs, 1);
        check("mrst_de", de, 0);
        check("mrst_rgb", rgb, 0);
        check("mrst_fs", frame_start, 0);
        check("mrst_pend", map_pending, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_fs", frame_start, 1);
        check("post_rst_de", de, 1);
        wait_out(9, 13);
        check("disp_cleared", rgb, C_BLACK);
        check("post_rst_pend", map_pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
